sqrt_job_sequencer: RTL and testbench
=====================================

# sqrt_job_sequencer

Front-end sequencer for the iterative square-root core. It accepts operands over a valid/ready stream and buffers up to two of them. It launches the core one job at a time, waits for the core to finish, and presents the root plus an exactness flag on a valid/ready output stream. It sits directly upstream and downstream of the square-root core and is the only block that drives the core's start and operand inputs.

## Interface
- `WIDTH`, default 8: operand width. Must be even. Root width is `WIDTH/2`.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before a job is aborted. Used only with the macro defined.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `in_valid_i`, in, 1: operand offered.
- `in_ready_o`, out, 1: operand accepted when both `in_valid_i` and `in_ready_o` are 1.
- `in_data_i`, in, `WIDTH`: unsigned operand.
- `out_valid_o`, out, 1: result held.
- `out_ready_i`, in, 1: result consumed when both `out_valid_o` and `out_ready_i` are 1.
- `out_root_o`, out, `WIDTH/2`: floor(sqrt(operand)).
- `out_exact_o`, out, 1: 1 when root*root == operand.
- `out_err_o`, out, 1: job aborted by timeout.
- `core_start_o`, out, 1: one-cycle launch pulse to the core.
- `core_operand_o`, out, `WIDTH`: operand of the job in flight.
- `core_ready_i`, in, 1: core idle/done level.
- `core_root_i`, in, `WIDTH/2`: core result, valid while `core_ready_i`=1 after a job.

## Operation
- Input FIFO: 2 entries with a 2-bit count.
  - `in_ready_o` = (count != 2). It is registered-state only and does not look ahead to a same-cycle pop.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, LAUNCH, ARM, WAIT, HOLD.
- IDLE: if the FIFO is non-empty, go to LAUNCH.
- LAUNCH:
  - `core_start_o`=1 for exactly this cycle.
  - The FIFO head is popped into `op_q`.
  - Go to ARM.
- ARM: `core_ready_i` is ignored because the core is still dropping it. Go to WAIT.
- WAIT:
  - On `core_ready_i`=1, capture `core_root_i` into `root_q`.
  - Compute exact = (`core_root_i` * `core_root_i` == `op_q`) using a `WIDTH`-bit product with no truncation.
  - Set `err_q`=0 and go to HOLD.
- HOLD:
  - `out_valid_o`=1 and the outputs are stable.
  - On `out_ready_i`=1, go to LAUNCH if the FIFO is non-empty, else IDLE.
- `core_operand_o` = `op_q`. It is stable from the LAUNCH edge until the next LAUNCH.
- `out_*` are driven from the capture registers. Their values outside HOLD are don't-care for consumers but are held.

## Timing
- Reset values:
  - State IDLE, FIFO empty, `in_ready_o`=1.
  - `out_valid_o`=0, `out_root_o`=0, `out_exact_o`=0, `out_err_o`=0.
  - `core_start_o`=0, `core_operand_o`=0.
- Operand accepted at edge E0 with the sequencer idle and the FIFO empty:
  - LAUNCH during cycle E1–E2.
  - ARM during E2–E3.
  - WAIT from E3.
  - `out_valid_o` rises on the edge that samples `core_ready_i`=1 in WAIT.
- Back-to-back jobs: HOLD goes straight to LAUNCH on consume, so there are no idle cycles between jobs.
- Reset asserted mid-job: all state clears immediately. The in-flight and buffered operands are discarded. No `core_start_o` pulse is emitted during or at release of reset.
- An operand accepted while in HOLD is queued. At most 3 jobs are outstanding: 2 in the FIFO and 1 in flight.

## Configuration
- `SQRT_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT and clears on entry.
  - When it reaches `TIMEOUT` without `core_ready_i`, go to HOLD with `out_root_o` = all ones, `out_exact_o`=0, `out_err_o`=1.
  - The next LAUNCH proceeds normally.
- Macro undefined: no counter. WAIT is unbounded and `out_err_o` is tied 0.

## Test plan
- `WIDTH`=8, behavioral core with 10-cycle latency. Push 49, 50, 0, 255 -> results 7/exact1, 7/exact0, 0/exact1, 15/exact0, in order, with `out_err_o`=0.
- Hold `out_ready_i`=0 and push 4 operands. `in_ready_o` falls after the 3rd accept (1 in flight + 2 buffered). Releasing `out_ready_i` yields all 3 results in order, and the 4th operand is then accepted.
- Count `core_start_o` pulses: exactly one per accepted operand, each 1 cycle wide. `core_operand_o` equals the operand from LAUNCH through HOLD.
- Assert `rst` during WAIT. The next cycle shows `out_valid_o`=0 and `in_ready_o`=1. The FIFO is empty, so there is no further launch after release.
- With `SQRT_SEQ_TIMEOUT_EN` defined, `TIMEOUT`=64, and a core that never reasserts ready: after 64 WAIT cycles, `out_valid_o`=1, `out_root_o`=0xF, `out_err_o`=1. With the macro undefined, the sequencer stays in WAIT.
- Push and consume in the same cycle with the FIFO full. The count stays 2 and `in_ready_o` stays 0 that cycle.

Source files
------------

// File: rtl/sqrt_job_sequencer_if.sv
// sqrt_job_sequencer_if
//   Operand input stream and result output stream of the square-root job
//   sequencer, grouped so the sequencer and its neighbours share one bundle.
//   Parameter WIDTH: operand width (even); the root is WIDTH/2 bits.
//   Signals:
//     in_valid_i / in_ready_o / in_data_i : operand stream into the sequencer
//     out_valid_o / out_ready_i           : result stream out of the sequencer
//     out_root_o, out_exact_o, out_err_o  : result payload
//   Modports:
//     slave  - the sequencer side
//     master - the producer/consumer side
interface sqrt_job_sequencer_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [WIDTH-1:0]     in_data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [WIDTH/2-1:0]   out_root_o;
  logic                 out_exact_o;
  logic                 out_err_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_root_o, out_exact_o, out_err_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_root_o, out_exact_o, out_err_o
  );
endinterface

// File: rtl/sqrt_job_sequencer.sv
// sqrt_job_sequencer
//   Front-end sequencer for the iterative square-root core. Buffers up to two
//   operands in a small FIFO, launches the core one job at a time, waits for
//   it to finish and holds the root plus an exactness flag on the output
//   stream until consumed.
//   Parameters:
//     WIDTH   - operand width (even); root width is WIDTH/2
//     TIMEOUT - WAIT-cycle limit before a job is aborted (timeout build only)
//   Ports:
//     clk, rst        - clock (rising edge), asynchronous active-high reset
//     bus             - operand/result streams (sqrt_job_sequencer_if.slave)
//     core_start_o    - one-cycle launch pulse to the core
//     core_operand_o  - operand of the job in flight
//     core_ready_i    - core idle/done level
//     core_root_i     - core result, valid while core_ready_i is high
//   Optional feature: define SQRT_SEQ_TIMEOUT_EN to abort jobs whose core
//   never reports done within TIMEOUT WAIT cycles (result all ones, err=1).
module sqrt_job_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sqrt_job_sequencer_if.slave  bus,
  output logic                 core_start_o,
  output logic [WIDTH-1:0]     core_operand_o,
  input  logic                 core_ready_i,
  input  logic [WIDTH/2-1:0]   core_root_i
);

  localparam int RW = WIDTH / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_ARM, S_WAIT, S_HOLD
  } state_t;

  state_t           state;
  logic             start_q;
  logic [WIDTH-1:0] op_q;
  logic [RW-1:0]    root_q;
  logic             exact_q;
  logic             valid_q;

  // Root squared fits exactly in WIDTH bits, so no product bits are lost.
  function automatic logic is_exact(input logic [RW-1:0] r,
                                    input logic [WIDTH-1:0] op);
    logic [WIDTH-1:0] sq;
    sq = {{RW{1'b0}}, r} * {{RW{1'b0}}, r};
    return (sq == op);
  endfunction

  // Two-entry operand FIFO
  logic [WIDTH-1:0] fifo_mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // Readiness is from registered count only; a same-cycle pop does not free a slot early.
  assign push = bus.in_valid_i && (count != 2'd2);
  // The head is popped on the edge that enters LAUNCH, so op_q is valid with the start pulse.
  assign pop  = (count != 2'd0) &&
                ((state == S_IDLE) || ((state == S_HOLD) && bus.out_ready_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.in_data_i;
  end

`ifdef SQRT_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
`endif

  // Job FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      op_q    <= '0;
      root_q  <= '0;
      exact_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef SQRT_SEQ_TIMEOUT_EN
      wait_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            state   <= S_LAUNCH;
            start_q <= 1'b1;
            op_q    <= fifo_mem[rd_ptr];
          end
        end
        S_LAUNCH: begin
          state <= S_ARM;
        end
        S_ARM: begin
          // The core is still dropping ready here, so it is not sampled.
          state <= S_WAIT;
`ifdef SQRT_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (core_ready_i) begin
            root_q  <= core_root_i;
            exact_q <= is_exact(core_root_i, op_q);
            valid_q <= 1'b1;
            state   <= S_HOLD;
`ifdef SQRT_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            root_q  <= '1;
            exact_q <= 1'b0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state   <= S_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        S_HOLD: begin
          if (bus.out_ready_i) begin
            valid_q <= 1'b0;
            if (pop) begin
              state   <= S_LAUNCH;
              start_q <= 1'b1;
              op_q    <= fifo_mem[rd_ptr];
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (count != 2'd2);
  assign bus.out_valid_o = valid_q;
  assign bus.out_root_o  = root_q;
  assign bus.out_exact_o = exact_q;
`ifdef SQRT_SEQ_TIMEOUT_EN
  assign bus.out_err_o   = err_q;
`else
  assign bus.out_err_o   = 1'b0;
`endif
  assign core_start_o    = start_q;
  assign core_operand_o  = op_q;

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// Testbench for sqrt_job_sequencer (WIDTH=8, TIMEOUT=64) with a behavioural
// square-root core of 10-cycle latency. Results are checked against a
// queue-based model of accepted operands and floor-sqrt arithmetic.
module tb_sqrt_job_sequencer;
  localparam int W   = 8;
  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         core_start_o;
  logic [W-1:0] core_operand_o;
  logic         core_ready_i;
  logic [W/2-1:0] core_root_i;

  sqrt_job_sequencer_if #(.WIDTH(W)) bus ();

  sqrt_job_sequencer #(.WIDTH(W), .TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .core_start_o  (core_start_o),
    .core_operand_o(core_operand_o),
    .core_ready_i  (core_ready_i),
    .core_root_i   (core_root_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Behavioural core: drops ready on start, reports root LAT cycles later.
  bit   hang = 0;
  int   c_cnt;
  int   c_op;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_ready_i <= 1'b1;
      core_root_i  <= '0;
      c_cnt        <= 0;
      c_op         <= 0;
    end else if (core_start_o) begin
      core_ready_i <= 1'b0;
      c_cnt        <= LAT;
      c_op         <= int'(core_operand_o);
    end else if (c_cnt == 1) begin
      c_cnt <= 0;
      if (!hang) begin
        core_ready_i <= 1'b1;
        core_root_i  <= 4'(isqrt(c_op));
      end
    end else if (c_cnt > 1) begin
      c_cnt <= c_cnt - 1;
    end
  end

  // Model: packed result = err*32 + exact*16 + root
  int  accq[$];
  int  resq[$];
  int  log_q[$];
  int  acc, launches, last_op, prev_out;
  bit  prev_start, prev_valid, prev_hs;

  function automatic int expect_res(input int op);
    int r;
`ifdef SQRT_SEQ_TIMEOUT_EN
    if (hang) return 32 + 15;
`endif
    r = isqrt(op);
    return ((r * r == op) ? 16 : 0) + r;
  endfunction

  function automatic int out_now();
    return (bus.out_err_o ? 32 : 0) + (bus.out_exact_o ? 16 : 0) + int'(bus.out_root_o);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      accq.delete(); resq.delete();
      acc = 0; launches = 0; last_op = 0; prev_out = 0;
      prev_start = 0; prev_valid = 0; prev_hs = 0;
    end else begin
      if (core_start_o) begin
        chk("start_width", int'(prev_start), 0);
        if (accq.size() == 0) chk("launch_without_job", 1, 0);
        else begin
          last_op = accq.pop_front();
          chk("launch_operand", int'(core_operand_o), last_op);
          resq.push_back(expect_res(last_op));
        end
        launches++;
      end else begin
        chk("operand_stable", int'(core_operand_o), last_op);
      end
      chk("in_ready", int'(bus.in_ready_o), int'((acc - launches) != 2));
      if (bus.out_valid_o && prev_valid && !prev_hs)
        chk("out_stable", out_now(), prev_out);
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (resq.size() == 0) chk("result_without_job", 1, 0);
        else chk("result", out_now(), resq.pop_front());
        log_q.push_back(out_now());
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        accq.push_back(int'(bus.in_data_i));
        acc++;
      end
      prev_start = core_start_o;
      prev_valid = bus.out_valid_o;
      prev_hs    = bus.out_valid_o && bus.out_ready_i;
      prev_out   = out_now();
    end
  end

  task automatic push(input int op);
    int n;
    n = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = W'(op);
    while (!bus.in_ready_o && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) chk("push_timeout", 1, 0);
    else begin
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int n, input int bound);
    n = 0;
    while (!bus.out_valid_o && n < bound) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((accq.size() != 0 || resq.size() != 0 || bus.out_valid_o) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_in_time", int'(n < 3000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid_o), 0);
    chk("rst_out_root",  int'(bus.out_root_o), 0);
    chk("rst_out_exact", int'(bus.out_exact_o), 0);
    chk("rst_out_err",   int'(bus.out_err_o), 0);
    chk("rst_start",     int'(core_start_o), 0);
    chk("rst_operand",   int'(core_operand_o), 0);
    chk("rst_in_ready",  int'(bus.in_ready_o), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // First-job latency and the four reference operands
    log_q.delete();
    bus.out_ready_i = 1'b1;
    push(49);
    wait_valid(n, 100);
    chk("first_latency", n, 13);
    push(50); push(0); push(255);
    wait_drain();
    chk("ref_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("ref_49",  log_q[0], 16 + 7);
      chk("ref_50",  log_q[1], 7);
      chk("ref_0",   log_q[2], 16 + 0);
      chk("ref_255", log_q[3], 15);
    end

    // Back-pressure: 3 outstanding, then consume while full
    log_q.delete();
    bus.out_ready_i = 1'b0;
    push(11); push(22); push(33);
    chk("full_after_3", int'(bus.in_ready_o), 0);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 8'd44;
    wait_valid(n, 100);
    chk("hold_reached", int'(n < 100), 1);
    bus.out_ready_i = 1'b1;
    #1;
    chk("full_consume_in_ready", int'(bus.in_ready_o), 0);
    @(posedge clk); #1;
    chk("slot_freed", int'(bus.in_ready_o), 1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    wait_drain();
    chk("bp_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("bp_11", log_q[0], 3);
      chk("bp_22", log_q[1], 4);
      chk("bp_33", log_q[2], 5);
      chk("bp_44", log_q[3], 6);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid_i  = ($urandom_range(0, 2) != 0);
      bus.in_data_i   = W'($urandom_range(0, 255));
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    wait_drain();
    chk("one_start_per_accept", launches, acc);

    // Core that never reports done
    hang = 1;
    base = acc;
    push(200);
`ifdef SQRT_SEQ_TIMEOUT_EN
    wait_valid(n, 300);
    chk("timeout_latency", n, 67);
    chk("timeout_root", int'(bus.out_root_o), 15);
    chk("timeout_err",  int'(bus.out_err_o), 1);
    wait_drain();
    hang = 0;
    log_q.delete();
    push(49);
    wait_drain();
    chk("after_timeout", (log_q.size() == 1) ? log_q[0] : -1, 16 + 7);
`else
    repeat (200) @(posedge clk);
    #1;
    chk("stuck_in_wait", int'(bus.out_valid_o), 0);
    chk("stuck_accepts", acc - base, 1);
    hang = 0;
`endif

    // Reset mid-job with operands buffered
    push(100);
    push(101);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid_o), 0);
    chk("midrst_in_ready",  int'(bus.in_ready_o), 1);
    chk("midrst_start",     int'(core_start_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("no_launch_after_rst", launches, 0);
    chk("idle_after_rst", int'(bus.out_valid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
